// File: rtl/lieat_idu_oitf_fifo.sv
// Outstanding-instruction tracking FIFO: in-order allocate/retire, out-of-order completion by tag,
// with RAW/WAW hazard detection for dispatch and an early RAW check for the IFU rs1 read.
module lieat_idu_oitf_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RGIDX_W = 5,
  parameter int unsigned TAG_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_ena,
  output logic               disp_rdy,
  output logic [TAG_W-1:0]   disp_tag,
  input  logic               disp_rs1en,
  input  logic               disp_rs2en,
  input  logic               disp_rdwen,
  input  logic [RGIDX_W-1:0] disp_rs1,
  input  logic [RGIDX_W-1:0] disp_rs2,
  input  logic [RGIDX_W-1:0] disp_rd,
  input  logic               cmpl_ena,
  input  logic [TAG_W-1:0]   cmpl_tag,
  input  logic               flush,
  input  logic [RGIDX_W-1:0] ifu_dep_rs1,
  input  logic [RGIDX_W-1:0] wbu_dep_rd,
  output logic               raw_dep,
  output logic               waw_dep,
  output logic               ifu_dep,
  output logic               oitf_empty,
  output logic               oitf_full,
  output logic [TAG_W:0]     oitf_cnt
);

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   done_q, done_d;
  logic [DEPTH-1:0]   rdwen_q, rdwen_d;
  logic [RGIDX_W-1:0] rd_q [DEPTH];
  logic [RGIDX_W-1:0] rd_d [DEPTH];
  logic [TAG_W:0]     wptr_q, wptr_d;
  logic [TAG_W:0]     rptr_q, rptr_d;

  logic [TAG_W-1:0] widx, ridx;
  logic             retire;

  assign widx = wptr_q[TAG_W-1:0];
  assign ridx = rptr_q[TAG_W-1:0];

  // MSB is the wrap bit: equal index with differing wrap means full.
  assign oitf_full  = (widx == ridx) && (wptr_q[TAG_W] != rptr_q[TAG_W]);
  assign oitf_empty = (wptr_q == rptr_q);
  assign oitf_cnt   = wptr_q - rptr_q;
  assign disp_rdy   = ~oitf_full;
  assign disp_tag   = widx;
  assign retire     = valid_q[ridx] & done_q[ridx];

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    rdwen_d = rdwen_q;
    rd_d    = rd_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (retire) begin
        valid_d[ridx] = 1'b0;
        done_d[ridx]  = 1'b0;
        rptr_d        = rptr_q + (TAG_W + 1)'(1);
      end
      if (cmpl_ena && valid_q[cmpl_tag] && !done_q[cmpl_tag]) begin
        done_d[cmpl_tag] = 1'b1;
      end
      // Never collides with the retiring slot: widx == ridx only when empty or full.
      if (disp_ena && disp_rdy) begin
        valid_d[widx] = 1'b1;
        done_d[widx]  = 1'b0;
        rdwen_d[widx] = disp_rdwen & (disp_rd != '0);
        rd_d[widx]    = disp_rd;
        wptr_d        = wptr_q + (TAG_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
      rdwen_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      rdwen_q <= rdwen_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i] <= rd_d[i];
      end
    end
  end

  always_comb begin
    logic pend, live;
    raw_dep = 1'b0;
    waw_dep = 1'b0;
    ifu_dep = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pend = valid_q[i] & ~done_q[i] & rdwen_q[i];
      // A completion in this very cycle already resolves the dispatch-side hazard.
      live = pend & ~(cmpl_ena & (cmpl_tag == TAG_W'(i)));
      if (live && ((disp_rs1en && disp_rs1 == rd_q[i]) || (disp_rs2en && disp_rs2 == rd_q[i]))) begin
        raw_dep = 1'b1;
      end
      if (live && wbu_dep_rd == rd_q[i]) begin
        waw_dep = 1'b1;
      end
      if (pend && ifu_dep_rs1 == rd_q[i]) begin
        ifu_dep = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lieat_idu_oitf_fifo.sv
// Self-checking bench for lieat_idu_oitf_fifo: queue-based reference model plus directed checks.
module tb_lieat_idu_oitf_fifo;
  localparam int DEPTH = 4;
  localparam int RW    = 5;
  localparam int TW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          disp_ena = 0, disp_rs1en = 0, disp_rs2en = 0, disp_rdwen = 0;
  logic [RW-1:0] disp_rs1 = '0, disp_rs2 = '0, disp_rd = '0, ifu_dep_rs1 = '0, wbu_dep_rd = '0;
  logic          cmpl_ena = 0, flush = 0;
  logic [TW-1:0] cmpl_tag = '0;
  logic          disp_rdy, raw_dep, waw_dep, ifu_dep, oitf_empty, oitf_full;
  logic [TW-1:0] disp_tag;
  logic [TW:0]   oitf_cnt;

  lieat_idu_oitf_fifo #(.DEPTH(DEPTH), .RGIDX_W(RW)) dut (
    .clk(clk), .rst(rst), .disp_ena(disp_ena), .disp_rdy(disp_rdy), .disp_tag(disp_tag),
    .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en), .disp_rdwen(disp_rdwen),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rd(disp_rd),
    .cmpl_ena(cmpl_ena), .cmpl_tag(cmpl_tag), .flush(flush),
    .ifu_dep_rs1(ifu_dep_rs1), .wbu_dep_rd(wbu_dep_rd),
    .raw_dep(raw_dep), .waw_dep(waw_dep), .ifu_dep(ifu_dep),
    .oitf_empty(oitf_empty), .oitf_full(oitf_full), .oitf_cnt(oitf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int tag; bit done; bit rdwen; int rd;} ent_t;
  ent_t q[$];
  int   next_tag = 0;
  int   last_tag = -1;
  bit   wrap_seen = 0;
  int   checks = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_raw();
    foreach (q[i]) begin
      if (!q[i].done && q[i].rdwen && !(cmpl_ena && cmpl_tag == q[i].tag) &&
          ((disp_rs1en && disp_rs1 == q[i].rd) || (disp_rs2en && disp_rs2 == q[i].rd))) return 1;
    end
    return 0;
  endfunction

  function automatic bit m_waw();
    foreach (q[i]) begin
      if (!q[i].done && q[i].rdwen && !(cmpl_ena && cmpl_tag == q[i].tag) &&
          wbu_dep_rd == q[i].rd) return 1;
    end
    return 0;
  endfunction

  function automatic bit m_ifu();
    foreach (q[i]) if (!q[i].done && q[i].rdwen && ifu_dep_rs1 == q[i].rd) return 1;
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_edge();
    bit ret, acc;
    if (rst || flush) begin
      q.delete();
      next_tag = 0;
      last_tag = -1;
      return;
    end
    ret = (q.size() > 0) && q[0].done;
    acc = disp_ena && (q.size() < DEPTH);
    if (cmpl_ena) foreach (q[i]) if (q[i].tag == cmpl_tag) q[i].done = 1;
    if (ret) void'(q.pop_front());
    if (acc) begin
      ent_t e;
      e.tag = next_tag % DEPTH;
      e.done = 0;
      e.rdwen = disp_rdwen && (disp_rd != 0);
      e.rd = disp_rd;
      q.push_back(e);
      if (last_tag == DEPTH - 1 && e.tag == 0) wrap_seen = 1;
      last_tag = e.tag;
      next_tag++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("disp_rdy", disp_rdy, q.size() < DEPTH);
      chk("disp_tag", disp_tag, next_tag % DEPTH);
      chk("oitf_cnt", oitf_cnt, q.size());
      chk("oitf_empty", oitf_empty, q.size() == 0);
      chk("oitf_full", oitf_full, q.size() == DEPTH);
      chk("raw_dep", raw_dep, m_raw());
      chk("waw_dep", waw_dep, m_waw());
      chk("ifu_dep", ifu_dep, m_ifu());
    end
  end

  task automatic idle();
    disp_ena = 0; cmpl_ena = 0; flush = 0;
    disp_rs1en = 0; disp_rs2en = 0; disp_rdwen = 0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1;
    step();
    flush = 0;
  endtask

  initial begin
    step(); step();
    rst = 0;
    #1;
    chk("rst_rdy", disp_rdy, 1);
    chk("rst_tag", disp_tag, 0);
    chk("rst_empty", oitf_empty, 1);
    chk("rst_full", oitf_full, 0);
    chk("rst_cnt", oitf_cnt, 0);
    chk("rst_deps", {raw_dep, waw_dep, ifu_dep}, 0);

    // Fill to full, then try one more.
    disp_ena = 1; disp_rdwen = 1;
    for (int i = 0; i < 4; i++) begin
      disp_rd = RW'(5 + i);
      chk("fill_tag", disp_tag, i);
      step();
    end
    chk("fill_full", oitf_full, 1);
    chk("fill_rdy", disp_rdy, 0);
    chk("fill_cnt", oitf_cnt, 4);
    disp_rd = 9;
    step();
    chk("over_cnt", oitf_cnt, 4);
    chk("over_tag", disp_tag, 0);
    do_flush();

    // RAW masked by same-cycle completion; IFU check is not.
    disp_ena = 1; disp_rdwen = 1; disp_rd = 5;
    step();
    idle();
    disp_rs1en = 1; disp_rs1 = 5; ifu_dep_rs1 = 5; wbu_dep_rd = 5;
    #1;
    chk("raw_hit", raw_dep, 1);
    chk("waw_hit", waw_dep, 1);
    chk("ifu_hit", ifu_dep, 1);
    cmpl_ena = 1; cmpl_tag = 0;
    #1;
    chk("raw_mask", raw_dep, 0);
    chk("waw_mask", waw_dep, 0);
    chk("ifu_nomask", ifu_dep, 1);
    step();
    cmpl_ena = 0;
    #1;
    chk("done_cnt", oitf_cnt, 1);
    chk("done_ifu", ifu_dep, 0);
    step();
    chk("retired_empty", oitf_empty, 1);
    do_flush();

    // Out-of-order completion waits for the head.
    disp_ena = 1; disp_rdwen = 1;
    for (int i = 0; i < 3; i++) begin
      disp_rd = RW'(10 + i);
      step();
    end
    idle();
    cmpl_ena = 1; cmpl_tag = 2; step();
    cmpl_tag = 1; step();
    cmpl_ena = 0; step();
    chk("ooo_hold", oitf_cnt, 3);
    cmpl_ena = 1; cmpl_tag = 0; step();
    cmpl_ena = 0;
    chk("ooo_c0", oitf_cnt, 3);
    step(); chk("ooo_r0", oitf_cnt, 2);
    step(); chk("ooo_r1", oitf_cnt, 1);
    step(); chk("ooo_r2", oitf_cnt, 0);
    chk("ooo_empty", oitf_empty, 1);

    // x0 destination never hazards.
    disp_ena = 1; disp_rdwen = 1; disp_rd = 0;
    step();
    idle();
    disp_rs1en = 1; disp_rs1 = 0; wbu_dep_rd = 0; ifu_dep_rs1 = 0;
    #1;
    chk("x0_raw", raw_dep, 0);
    chk("x0_waw", waw_dep, 0);
    chk("x0_ifu", ifu_dep, 0);
    do_flush();

    // Flush beats same-cycle dispatch and completion.
    disp_ena = 1; disp_rdwen = 1;
    for (int i = 0; i < 3; i++) begin
      disp_rd = RW'(20 + i);
      step();
    end
    flush = 1; cmpl_ena = 1; cmpl_tag = 0; disp_rd = 3;
    step();
    idle();
    #1;
    chk("flush_cnt", oitf_cnt, 0);
    chk("flush_empty", oitf_empty, 1);
    chk("flush_tag", disp_tag, 0);

    // Random dispatch/complete traffic; model checks every cycle.
    for (int i = 0; i < 120; i++) begin
      disp_ena   = ($urandom_range(0, 9) < 6);
      disp_rdwen = $urandom_range(0, 1);
      disp_rd    = RW'($urandom_range(0, 7));
      disp_rs1en = $urandom_range(0, 1);
      disp_rs2en = $urandom_range(0, 1);
      disp_rs1   = RW'($urandom_range(0, 7));
      disp_rs2   = RW'($urandom_range(0, 7));
      ifu_dep_rs1 = RW'($urandom_range(0, 7));
      wbu_dep_rd  = RW'($urandom_range(0, 7));
      cmpl_ena   = ($urandom_range(0, 9) < 5);
      cmpl_tag   = TW'($urandom_range(0, DEPTH - 1));
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      cmpl_ena = 1; cmpl_tag = TW'(i); step();
    end
    cmpl_ena = 0;
    repeat (6) step();
    chk("rand_wrap_seen", wrap_seen, 1);
    chk("rand_drain_empty", oitf_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/lieat_idu_oitf_fifo.md
# lieat_idu_oitf_fifo

Parametrised outstanding-instruction tracking FIFO for the IDU dispatch stage, replacing the fixed one-slot-per-unit tracker. Holds up to DEPTH in-flight long-latency instructions in dispatch order, accepts out-of-order completion by tag, and retires in order from the head. Flags RAW/WAW hazards for the dispatching instruction and a RAW hazard for the IFU's early rs1 read. Supports a pipeline flush.

## Interface
- DEPTH, 4, entry count; power of two, ≥2
- RGIDX_W, 5, register index width
- TAG_W, $clog2(DEPTH), tag/pointer width (derived, do not override)

- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- disp_ena  in  1  dispatch request; allocates an entry only when disp_rdy=1
- disp_rdy  out  1  ~full
- disp_tag  out  TAG_W  tag that the current dispatch receives (= write pointer index)
- disp_rs1en / disp_rs2en / disp_rdwen  in  1 each  operand and destination enables
- disp_rs1 / disp_rs2 / disp_rd  in  RGIDX_W each  register indices
- cmpl_ena  in  1  completion strobe from a long-latency unit
- cmpl_tag  in  TAG_W  tag being completed
- flush  in  1  discard all entries
- ifu_dep_rs1  in  RGIDX_W  IFU early-read rs1 index
- wbu_dep_rd  in  RGIDX_W  destination index checked for WAW
- raw_dep  out  1  dispatch rs1/rs2 hazard
- waw_dep  out  1  wbu_dep_rd hazard
- ifu_dep  out  1  IFU rs1 hazard
- oitf_empty  out  1  no valid entries
- oitf_full  out  1  DEPTH valid entries
- oitf_cnt  out  TAG_W+1  valid entry count

## Operation
- Per entry state: valid, done, rdwen, rd. Stored rdwen = disp_rdwen & (disp_rd != 0). x0 never creates a hazard.
- Pointers wptr/rptr are TAG_W+1 bits wide, with the MSB as the wrap bit. Index = low TAG_W bits. full = (index equal) & (wrap differs). empty = pointers equal.
- Dispatch: disp_ena & disp_rdy & ~flush. Sets entry[wptr] valid=1, done=0, latches rdwen and rd, then increments wptr modulo 2·DEPTH.
- Completion: cmpl_ena & ~flush with entry[cmpl_tag] valid & ~done sets done=1. Completion of an invalid or already-done entry is ignored.
- Retire: when entry[rptr] is valid & done, clear valid and increment rptr. At most one retire per cycle.
- Live entry (for raw/waw): valid & ~done & ~(cmpl_ena & cmpl_tag==index). A same-cycle completion masks the hazard.
- raw_dep = OR over live entries of rdwen & ((disp_rs1en & rs1==rd) | (disp_rs2en & rs2==rd)).
- waw_dep = OR over live entries of rdwen & (wbu_dep_rd==rd).
- ifu_dep = OR over entries with valid & ~done & rdwen & (ifu_dep_rs1==rd). This check is not masked by same-cycle completion.
- raw_dep, waw_dep and ifu_dep are independent of disp_ena; IDU gating is external.
- oitf_cnt = wptr − rptr (modulo 2·DEPTH).
- flush: at the next edge, all valid and done bits are 0 and wptr = rptr = 0. A dispatch or completion in the same cycle is dropped. flush has priority over everything except rst.

## Timing
- All outputs are combinational from registered state plus same-cycle inputs. No output registers.
- Dispatch → entry visible to hazard checks: next cycle. Same-cycle dispatch does not self-check.
- Completion → done: next edge. Earliest retire is the edge after that, so an entry completed in cycle N retires at the end of cycle N+1 if it is at the head.
- Simultaneous dispatch and retire: both occur. cnt is unchanged. When full, disp_rdy=0 regardless of a same-cycle retire.
- Out-of-order completion: younger done entries wait for the head. cnt counts them until retire.
- Wrap-around: after 2·DEPTH dispatches the pointers return to 0 and full/empty stay correct.
- Reset values: disp_rdy=1, disp_tag=0, oitf_empty=1, oitf_full=0, oitf_cnt=0, raw_dep=waw_dep=ifu_dep=0. rst in mid-operation discards all entries like flush.

## Test plan
- Reset, then DEPTH=4, dispatch rd=5,6,7,8 back-to-back → tags 0,1,2,3. After the 4th, oitf_full=1, disp_rdy=0, cnt=4. A 5th disp_ena is ignored.
- Entry rd=5 outstanding; disp_rs1en=1, rs1=5 → raw_dep=1. Same cycle cmpl_tag=that tag → raw_dep=0, while ifu_dep with ifu_dep_rs1=5 stays 1.
- Dispatch tags 0,1,2. Complete 2, then 1 → no retire, cnt=3. Complete 0 → tags 0,1,2 retire on three consecutive cycles, then oitf_empty=1.
- Dispatch with disp_rdwen=1, rd=0, then rs1=0 and wbu_dep_rd=0 → raw_dep=0, waw_dep=0.
- Fill 3 entries, assert flush with disp_ena=1 and cmpl_ena=1 → next cycle cnt=0, empty=1, disp_tag=0.
- Run 20 dispatch/complete/retire rounds with random order → cnt matches the reference model, no overflow, and tags wrap 3→0.
